// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue interface between the decoder (master) and hazard_scoreboard (slave).
// Carries the decoded ID operands plus the stall/issue/forwarding responses.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 2,
    parameter int CNT_W      = 2
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic                  id_rs1_used;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic                  id_halt;
    logic                  flush;
    logic                  stall;
    logic                  issue;
    logic [CNT_W-1:0]      fwd1;
    logic [CNT_W-1:0]      fwd2;
    logic [CNT_W-1:0]      pending_cnt;
    logic                  halted;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
               id_reg_write, id_is_load, id_halt, flush,
        input  stall, issue, fwd1, fwd2, pending_cnt, halted
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
               id_reg_write, id_is_load, id_halt, flush,
        output stall, issue, fwd1, fwd2, pending_cnt, halted
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard and issue controller with HLT drain sequencing.
// Define HAZARD_SCOREBOARD_FWD_EN to enable forwarding (only load-use stalls).
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 2,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    hazard_scoreboard_if.slave sb
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                state, state_n;
    logic [DEPTH-1:0]      sb_v, sb_v_n;
    // WB never matches, so only entries 0..DEPTH-2 need their rd kept.
    logic [REG_ADDR_W-1:0] sb_rd [DEPTH-1];
    logic                  sb_ld0;
    logic [CNT_W-1:0]      pcnt;
    logic [DEPTH-2:0]      m1, m2;
    logic                  hazard;
    logic                  stall_c, issue_c;
    logic [CNT_W-1:0]      fwd1_c, fwd2_c;

    function automatic logic [CNT_W-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] youngest(input logic [DEPTH-2:0] m);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int k = DEPTH - 2; k >= 0; k--) if (m[k]) s = CNT_W'(k + 1);
        return s;
    endfunction

    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            m1[k] = sb.id_rs1_used && sb_v[k] && (sb_rd[k] == sb.id_rs1);
            m2[k] = sb.id_rs2_used && sb_v[k] && (sb_rd[k] == sb.id_rs2);
        end
    end

`ifdef HAZARD_SCOREBOARD_FWD_EN
    assign hazard = sb_ld0 && (m1[0] || m2[0]);
    assign fwd1_c = sb.id_valid ? youngest(m1) : '0;
    assign fwd2_c = sb.id_valid ? youngest(m2) : '0;
`else
    assign hazard = (|m1) || (|m2);
    assign fwd1_c = '0;
    assign fwd2_c = '0;
`endif

    always_comb begin
        state_n = state;
        stall_c = 1'b0;
        issue_c = 1'b0;
        unique case (state)
            RUN: begin
                stall_c = sb.id_valid && hazard;
                issue_c = sb.id_valid && !stall_c && !sb.flush;
                // HLT is accepted but never issued; a bubble follows it into EX.
                if (issue_c && sb.id_halt) begin
                    issue_c = 1'b0;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                stall_c = 1'b1;
                if (sb_v == '0) state_n = HALTED;
            end
            HALTED: stall_c = 1'b1;
            default: state_n = RUN;
        endcase
    end

    assign sb_v_n = {sb_v[DEPTH-2:0], issue_c && sb.id_reg_write};

    // ---- scoreboard stage boundary: EX (entry 0) .. WB (entry DEPTH-1)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            sb_v  <= '0;
            pcnt  <= '0;
        end else begin
            state <= state_n;
            sb_v  <= sb_v_n;
            pcnt  <= popcnt(sb_v_n);
        end
    end

    always_ff @(posedge clk) begin
        sb_rd[0] <= sb.id_rd;
        sb_ld0   <= sb.id_is_load;
        for (int k = 1; k < DEPTH - 1; k++) sb_rd[k] <= sb_rd[k-1];
    end

    assign sb.stall       = stall_c;
    assign sb.issue       = issue_c;
    assign sb.fwd1        = fwd1_c;
    assign sb.fwd2        = fwd2_c;
    assign sb.pending_cnt = pcnt;
    assign sb.halted      = (state == HALTED);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3) with a queue of expected outputs.
// FWD_EN-specific steps compile only when HAZARD_SCOREBOARD_FWD_EN is defined.
module tb_hazard_scoreboard;
    localparam int RW = 2;
    localparam int DP = 3;
    localparam int CW = 2;

    typedef struct {
        string          tag;
        logic           stall;
        logic           issue;
        logic [CW-1:0]  f1;
        logic [CW-1:0]  f2;
        logic [CW-1:0]  pc;
        logic           halted;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    hazard_scoreboard_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    hazard_scoreboard #(.REG_ADDR_W(RW), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RW-1:0] rs1, input logic u1,
                         input logic [RW-1:0] rs2, input logic u2, input logic [RW-1:0] rd,
                         input logic rw, input logic ld, input logic hlt, input logic fl);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs1_used  = u1;
        bus.id_rs2       = rs2;
        bus.id_rs2_used  = u2;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_is_load   = ld;
        bus.id_halt      = hlt;
        bus.flush        = fl;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string tag, input logic st, input logic is,
                              input logic [CW-1:0] f1, input logic [CW-1:0] f2,
                              input logic [CW-1:0] pc, input logic h);
        exp_t e;
        e.tag = tag; e.stall = st; e.issue = is; e.f1 = f1; e.f2 = f2; e.pc = pc; e.halted = h;
        q.push_back(e);
    endtask

    task automatic cmp1(input string tag, input string fld, input logic [CW-1:0] obs,
                        input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
        end
    endtask

    task automatic chk();
        exp_t e;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            cmp1(e.tag, "stall",  CW'(bus.stall),  CW'(e.stall));
            cmp1(e.tag, "issue",  CW'(bus.issue),  CW'(e.issue));
            cmp1(e.tag, "fwd1",   bus.fwd1,        e.f1);
            cmp1(e.tag, "fwd2",   bus.fwd2,        e.f2);
            cmp1(e.tag, "pcnt",   bus.pending_cnt, e.pc);
            cmp1(e.tag, "halted", CW'(bus.halted), CW'(e.halted));
        end
    endtask

    initial begin
        idle();
        expect_out("reset", 0, 0, 0, 0, 0, 0); chk();
        #2 reset_n = 1'b1;
        cyc();

`ifdef HAZARD_SCOREBOARD_FWD_EN
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        expect_out("fw_add", 0, 1, 0, 0, 0, 0); chk(); cyc();
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        expect_out("fw_dist1", 0, 1, 0, 1, 1, 0); chk(); cyc();
        idle(); cyc(); cyc(); cyc();
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        expect_out("fw_add2", 0, 1, 0, 0, 0, 0); chk(); cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("fw_gap", 0, 1, 0, 0, 1, 0); chk(); cyc();
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        expect_out("fw_dist2", 0, 1, 0, 2, 1, 0); chk(); cyc();
        idle(); cyc(); cyc(); cyc();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        expect_out("lw_issue", 0, 1, 0, 0, 0, 0); chk(); cyc();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_out("lw_use", 1, 0, 1, 0, 1, 0); chk(); cyc();
        expect_out("lw_fwd", 0, 1, 2, 0, 1, 0); chk(); cyc();
        idle(); cyc(); cyc(); cyc();
`else
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        expect_out("raw_add", 0, 1, 0, 0, 0, 0); chk(); cyc();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_out("raw_st1", 1, 0, 0, 0, 1, 0); chk(); cyc();
        expect_out("raw_st2", 1, 0, 0, 0, 1, 0); chk(); cyc();
        expect_out("raw_iss", 0, 1, 0, 0, 1, 0); chk(); cyc();
        idle();
        expect_out("raw_done", 0, 0, 0, 0, 0, 0); chk(); cyc(); cyc(); cyc();
`endif

        // flush kills a writer and a HLT; the following writer still issues
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        expect_out("fl_wr", 0, 0, 0, 0, 0, 0); chk(); cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        expect_out("fl_hlt", 0, 0, 0, 0, 0, 0); chk(); cyc();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        expect_out("fl_run", 0, 1, 0, 0, 0, 0); chk(); cyc();
        drive(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        expect_out("novalid", 0, 0, 0, 0, 1, 0); chk(); cyc();
        idle(); cyc(); cyc(); cyc();

        // three writers, then HLT drains the pipe
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 0, RW'(i), 1, 0, 0, 0);
            expect_out("wr", 0, 1, 0, 0, CW'(i - 1), 0); chk(); cyc();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_out("hlt_acc", 0, 0, 0, 0, 3, 0); chk(); cyc();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        expect_out("drain0", 1, 0, 0, 0, 2, 0); chk(); cyc();
        expect_out("drain1", 1, 0, 0, 0, 1, 0); chk(); cyc();
        expect_out("drain2", 1, 0, 0, 0, 0, 0); chk(); cyc();
        expect_out("halted", 1, 0, 0, 0, 0, 1); chk();
        for (int i = 0; i < 10; i++) begin
            cyc();
            drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 1'(i & 1));
            expect_out("sticky", 1, 0, 0, 0, 0, 1); chk();
        end

        // asynchronous reset in the middle of a drain
        reset_n = 1'b0; #1; reset_n = 1'b1;
        idle(); cyc();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 0, RW'(i), 1, 0, 0, 0);
            cyc();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc();
        idle();
        expect_out("mid_drain", 1, 0, 0, 0, 2, 0); chk();
        #2 reset_n = 1'b0;
        expect_out("async_rst", 0, 0, 0, 0, 0, 0); chk();
        cyc();
        #1 reset_n = 1'b1;
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        expect_out("rst_run", 0, 1, 0, 0, 0, 0); chk(); cyc();
        idle();
        expect_out("rst_pc", 0, 0, 0, 0, 1, 0); chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
